// File: rtl/pc_fetch_unit.sv
// PC generation and single-outstanding instruction fetch with redirect
// handling, a registered decode handoff and a delivered-instruction count.
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h100),
  parameter int PC_INC = 1,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HOLD, DROP
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0]  pc, pc_n;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  if_pc_n;
  logic [ILEN-1:0]  if_instr_n;
  logic             if_valid_n;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    target = branch_target;
    unique case (redirect_sel)
      2'd0: target = branch_target;
      2'd1: target = jump_target;
      2'd2: target = TRAP_VECTOR;
      2'd3: target = RESET_VECTOR;
    endcase
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= if_valid_n;
      if_pc       <= if_pc_n;
      if_instr    <= if_instr_n;
      fetch_count <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    if_valid_n = if_valid;
    if_pc_n    = if_pc;
    if_instr_n = if_instr;
    cnt_n      = fetch_count;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) pc_n = target;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n    = target;
          // an accepted request still owes us a response to swallow
          state_n = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n    = target;
          state_n = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          if_valid_n = 1'b1;
          if_pc_n    = pc;
          if_instr_n = imem_resp_data;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n       = target;
          if_valid_n = 1'b0;
          state_n    = REQ;
        end else if (if_ready) begin
          pc_n       = pc + XLEN'(PC_INC);
          if_valid_n = 1'b0;
          cnt_n      = fetch_count + CNT_W'(1);
          state_n    = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_n = target;
        if (imem_resp_valid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: directed fetch, stall, redirect,
// wrap and reset scenarios against a variable-latency IMEM model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_sel = 2'd0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_ready = 1'b0;

  logic        req_valid, if_valid;
  logic [31:0] req_addr, if_pc, if_instr;
  logic [15:0] fetch_count;

  logic        w_req_valid, w_if_valid;
  logic [31:0] w_req_addr, w_if_pc, w_if_instr;
  logic [1:0]  w_fetch_count;

  pc_fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .fetch_count(fetch_count)
  );

  // Runs in lockstep with u_dut but starts at the top of the address space
  pc_fetch_unit #(
    .RESET_VECTOR(32'hFFFF_FFFF), .CNT_W(2)
  ) u_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr),
    .if_ready(if_ready), .fetch_count(w_fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int del_cnt = 0;
  int lat = 1;
  bit chk_wrap = 1'b1;

  logic [31:0] req_q[$];
  logic [63:0] del_q[$];
  logic [31:0] wrap_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got unexpected or missing event", nm);
  endtask

  // IMEM model: one outstanding request, data = addr ^ C0DE0000
  logic        m_acc = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_paddr = '0;
  int          m_left = 0;

  always begin
    @(negedge clk);
    m_acc  = req_valid && imem_req_ready;
    m_addr = req_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hC0DE_0000 ^ m_paddr;
        m_pend = 1'b0;
      end
    end
    if (m_acc) begin
      m_paddr = m_addr;
      m_left  = lat - 1;
      if (m_left == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hC0DE_0000 ^ m_paddr;
      end else begin
        m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (req_valid && imem_req_ready) begin
      acc_cnt++;
      if (req_q.size() == 0) miss("req_unexpected");
      else chk("req_addr", 64'(req_addr), 64'(req_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (if_valid && if_ready && !redirect_valid) begin
      del_cnt++;
      if (del_q.size() == 0) miss("del_unexpected");
      else chk("del_pc_instr", {if_pc, if_instr}, del_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_wrap && w_if_valid && if_ready && !redirect_valid) begin
      if (wrap_q.size() == 0) miss("wrap_unexpected");
      else chk("wrap_pc", 64'(w_if_pc), 64'(wrap_q.pop_front()));
    end
  end

  task automatic wait_acc(input int n);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt >= n) break;
    end
    if (acc_cnt < n) miss("timeout_acc");
    #1;
  endtask

  task automatic wait_del(input int n);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (del_cnt >= n) break;
    end
    if (del_cnt < n) miss("timeout_del");
    #1;
  endtask

  task automatic redir(input logic [1:0] sel);
    redirect_sel   = sel;
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);

    // straight-line fetch, 1-cycle latency
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(32'(i));
      del_q.push_back({32'(i), 32'hC0DE_0000 ^ 32'(i)});
    end
    wrap_q.push_back(32'hFFFF_FFFF);
    wrap_q.push_back(32'h0);
    wrap_q.push_back(32'h1);
    wrap_q.push_back(32'h2);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    reset = 1'b0;
    wait_del(4);
    imem_req_ready = 1'b0;
    chk_wrap = 1'b0;
    chk("seq_count", 64'(fetch_count), 64'd4);
    chk("seq_stall_addr", 64'(req_addr), 64'd4);
    chk("wrap_count", 64'(w_fetch_count), 64'd0);
    chk("wrap_q_empty", 64'(wrap_q.size()), 64'd0);

    // decode back-pressure in HOLD
    req_q.push_back(32'h4);
    del_q.push_back({32'h4, 32'hC0DE_0004});
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    wait_acc(5);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !if_valid; i++) @(negedge clk);
    if (!if_valid) miss("timeout_hold");
    repeat (5) begin
      @(negedge clk);
      chk("hold_pc", 64'(if_pc), 64'h4);
      chk("hold_instr", 64'(if_instr), 64'hC0DE_0004);
      chk("hold_no_req", 64'(req_valid), 64'd0);
      chk("hold_count", 64'(fetch_count), 64'd4);
    end
    @(posedge clk);
    #1;
    if_ready = 1'b1;
    wait_del(5);
    chk("hold_done_count", 64'(fetch_count), 64'd5);

    // branch redirect in WAIT, latency 3
    lat = 3;
    req_q.push_back(32'h5);
    req_q.push_back(32'h40);
    del_q.push_back({32'h40, 32'hC0DE_0040});
    branch_target = 32'h40;
    jump_target = 32'h77;
    imem_req_ready = 1'b1;
    wait_acc(6);
    redir(2'd0);
    wait_acc(7);
    imem_req_ready = 1'b0;
    wait_del(6);
    chk("br_count", 64'(fetch_count), 64'd6);

    // trap redirect alongside the response
    lat = 1;
    req_q.push_back(32'h41);
    req_q.push_back(32'h100);
    del_q.push_back({32'h100, 32'hC0DE_0100});
    imem_req_ready = 1'b1;
    wait_acc(8);
    redir(2'd2);
    wait_acc(9);
    imem_req_ready = 1'b0;
    wait_del(7);
    chk("trap_count", 64'(fetch_count), 64'd7);

    // reset while a response is still outstanding
    lat = 3;
    req_q.push_back(32'h101);
    imem_req_ready = 1'b1;
    wait_acc(10);
    reset = 1'b1;
    imem_req_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_if_valid", 64'(if_valid), 64'd0);
      chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
    end
    chk("mid_rst_count", 64'(fetch_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lat = 1;
    req_q.push_back(32'h0);
    del_q.push_back({32'h0, 32'hC0DE_0000});
    imem_req_ready = 1'b1;
    wait_acc(11);
    imem_req_ready = 1'b0;
    wait_del(8);
    chk("post_rst_count", 64'(fetch_count), 64'd1);

    // jump redirect in HOLD while decode is accepting
    req_q.push_back(32'h1);
    req_q.push_back(32'h80);
    del_q.push_back({32'h80, 32'hC0DE_0080});
    jump_target = 32'h80;
    imem_req_ready = 1'b1;
    wait_acc(12);
    imem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    redir(2'd1);
    chk("jmp_kill_valid", 64'(if_valid), 64'd0);
    chk("jmp_kill_count", 64'(fetch_count), 64'd1);
    wait_acc(13);
    imem_req_ready = 1'b0;
    wait_del(9);
    chk("jmp_count", 64'(fetch_count), 64'd2);

    repeat (3) @(negedge clk);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("del_q_empty", 64'(del_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, PC and address width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded at reset.
REQ-004 Parameter TRAP_VECTOR, default 32'h100, trap redirect target.
REQ-005 Parameter PC_INC, default 1, sequential PC increment (word-addressed IMEM).
REQ-006 Parameter CNT_W, default 16, delivered-instruction counter width.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 redirect_valid  input  1  redirect PC this cycle.
REQ-010 redirect_sel  input  2  0=branch_target, 1=jump_target, 2=TRAP_VECTOR, 3=RESET_VECTOR.
REQ-011 branch_target  input  XLEN  branch redirect address.
REQ-012 jump_target  input  XLEN  jump redirect address.
REQ-013 imem_req_valid  output  1  fetch request.
REQ-014 imem_req_addr  output  XLEN  fetch address, equals current PC.
REQ-015 imem_req_ready  input  1  IMEM accepts request.
REQ-016 imem_resp_valid  input  1  IMEM returns data (variable latency, at most one outstanding).
REQ-017 imem_resp_data  input  ILEN  returned instruction.
REQ-018 if_valid  output  1  instruction available to decode.
REQ-019 if_pc  output  XLEN  PC of presented instruction.
REQ-020 if_instr  output  ILEN  presented instruction.
REQ-021 if_ready  input  1  decode accepts instruction.
REQ-022 fetch_count  output  CNT_W  number of instructions accepted by decode.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP.
REQ-024 IDLE: outputs inactive; SHALL go to REQ unconditionally on the next edge.
REQ-025 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready SHALL go to WAIT, else remain in REQ with address stable.
REQ-026 WAIT: on imem_resp_valid SHALL register if_instr=imem_resp_data and if_pc=pc, set if_valid=1, and go to HOLD.
REQ-027 HOLD: if_valid=1 with if_pc/if_instr stable; on if_ready SHALL clear if_valid, set pc=pc+PC_INC (modulo 2^XLEN, wrap without flag), increment fetch_count, and go to REQ.
REQ-028 Minimum latency from request acceptance to if_valid SHALL be one cycle after imem_resp_valid (response registered).
REQ-029 redirect_valid SHALL take priority over every other event in every state except IDLE: pc loads the target selected by redirect_sel, if_valid clears, and no counter increment occurs.
REQ-030 Redirect in HOLD with if_ready high SHALL discard the held instruction (not counted) and go to REQ.
REQ-031 Redirect in REQ without imem_req_ready, or in HOLD, SHALL go to REQ with the new PC.
REQ-032 Redirect in REQ with imem_req_ready high, or in WAIT without imem_resp_valid, SHALL go to DROP.
REQ-033 Redirect in WAIT with imem_resp_valid high SHALL discard that response and go to REQ.
REQ-034 DROP: imem_req_valid=0, if_valid=0; on imem_resp_valid SHALL discard the data and go to REQ. A further redirect updates pc and stays in DROP.
REQ-035 Redirect in IDLE SHALL load pc and proceed to REQ.
REQ-036 fetch_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-037 imem_req_valid SHALL never be high in WAIT, HOLD, DROP or IDLE (single outstanding request).

Reset
REQ-038 While reset is high: state=IDLE, pc=RESET_VECTOR, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, fetch_count=0, all applied asynchronously.
REQ-039 Reset asserted mid-transaction SHALL abandon any outstanding IMEM request; responses arriving in IDLE SHALL be ignored.

Verification
REQ-040 Reset release, IMEM ready=1, 1-cycle latency, if_ready=1 -> addresses 0,1,2,3 issued, if_pc 0,1,2,3 delivered, fetch_count=4.
REQ-041 if_ready=0 for 5 cycles in HOLD -> if_pc/if_instr constant, no new request, fetch_count unchanged.
REQ-042 Redirect sel=0, branch_target=0x40, in WAIT before response (latency 3) -> response discarded, next request addr=0x40, first delivered if_pc=0x40.
REQ-043 Redirect sel=2 in the same cycle as imem_resp_valid -> data discarded, next request addr=0x100.
REQ-044 pc=2^XLEN-1 with PC_INC=1 and CNT_W=2, 4 deliveries -> pc wraps to 0, fetch_count wraps to 0.
REQ-045 Reset asserted in WAIT, response arrives during reset -> if_valid stays 0, first request after release addr=RESET_VECTOR.
